// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller:
// state values, opcode/funct constants and small decode helpers.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LOAD   = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_MDWAIT = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_mode_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_LB      = 6'd32;
  localparam logic [5:0] OP_LH      = 6'd33;
  localparam logic [5:0] OP_LWL     = 6'd34;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_LBU     = 6'd36;
  localparam logic [5:0] OP_LHU     = 6'd37;
  localparam logic [5:0] OP_LWR     = 6'd38;
  localparam logic [5:0] OP_SB      = 6'd40;
  localparam logic [5:0] OP_SH      = 6'd41;
  localparam logic [5:0] OP_SW      = 6'd43;

  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_multdiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  endfunction

  function automatic logic is_div(input logic [5:0] fn);
    return (fn == F_DIV) || (fn == F_DIVU);
  endfunction

  function automatic logic is_mthilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && ((fn == F_MTHI) || (fn == F_MTLO));
  endfunction

  // Byte lanes for a store; address bits select the lane(s) within the word.
  function automatic logic [3:0] store_byteenable(input logic [5:0] op, input logic [1:0] ba);
    case (op)
      OP_SB:   return 4'b0001 << ba;
      OP_SH:   return ba[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_stall_counter.sv
// Loadable counter: down mode saturates at zero (MDWAIT), up mode counts
// consecutive events and is cleared by loading zero (bus timeout).
module stall_counter
  import control_pkg::*;
#(
  parameter int W = 6
) (
  input  logic      clk,
  input  logic      reset,
  input  cnt_mode_e mode_i,
  input  logic      load_i,
  input  logic [W-1:0] load_val_i,
  input  logic      en_i,
  output logic [W-1:0] count_o,
  output logic      zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (mode_i == CNT_UP) begin
        count_d = count_q + 1'b1;
      end else if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/control_fsm.sv
// Sequencing controller for the multi-cycle MIPS CPU: owns the CPU state,
// runs the bus handshake, gates commits and handles mult/div stalls and halt.
module control_fsm
  import control_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int BUS_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic [1:0] byte_addressing,
  input  logic       waitrequest,
  input  logic       pc_is_zero,
  output logic [2:0] state,
  output logic       read,
  output logic       write,
  output logic [3:0] byteenable,
  output logic       ir_write_enable,
  output logic       reg_commit,
  output logic       hilo_commit,
  output logic       multdiv_start,
  output logic       pc_write_enable,
  output logic       active,
  output logic       bus_error
);

  localparam int MD_MAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_MAX = (MD_MAX > BUS_TIMEOUT) ? MD_MAX : BUS_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = (BUS_TIMEOUT > 0) ? CW'(BUS_TIMEOUT - 1) : '0;

  state_e state_q, state_d;
  logic   bus_error_q, bus_error_d;

  logic          md_load, md_en, md_zero;
  logic [CW-1:0] md_load_val, md_count_unused;
  logic          bus_stall, to_zero_unused;
  logic [CW-1:0] to_count;

  stall_counter #(.W(CW)) u_md_counter (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (CNT_DOWN),
    .load_i    (md_load),
    .load_val_i(md_load_val),
    .en_i      (md_en),
    .count_o   (md_count_unused),
    .zero_o    (md_zero)
  );

  // Counts consecutive stalled bus cycles; any non-stall cycle reloads zero.
  stall_counter #(.W(CW)) u_to_counter (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (CNT_UP),
    .load_i    (!bus_stall),
    .load_val_i('0),
    .en_i      (bus_stall && (BUS_TIMEOUT > 0)),
    .count_o   (to_count),
    .zero_o    (to_zero_unused)
  );

  always_comb begin
    state_d         = state_q;
    bus_error_d     = bus_error_q;
    read            = 1'b0;
    write           = 1'b0;
    byteenable      = 4'b1111;
    ir_write_enable = 1'b0;
    reg_commit      = 1'b0;
    hilo_commit     = 1'b0;
    multdiv_start   = 1'b0;
    pc_write_enable = 1'b0;
    md_load         = 1'b0;
    md_load_val     = MULT_LOAD;
    md_en           = 1'b0;
    bus_stall       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (pc_is_zero) begin
            state_d = S_HALT;
          end else begin
            read = 1'b1;
            if (waitrequest) begin
              bus_stall = 1'b1;
            end else begin
              ir_write_enable = 1'b1;
              state_d         = S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (is_load(opcode) || is_store(opcode)) begin
            state_d = S_MEM;
          end else if (is_multdiv(opcode, function_code)) begin
            multdiv_start = 1'b1;
            md_load       = 1'b1;
            md_load_val   = is_div(function_code) ? DIV_LOAD : MULT_LOAD;
            state_d       = S_MDWAIT;
          end else begin
            reg_commit      = 1'b1;
            pc_write_enable = 1'b1;
            hilo_commit     = is_mthilo(opcode, function_code);
            state_d         = S_FETCH;
          end
        end
        S_MEM: begin
          if (is_load(opcode)) begin
            read = 1'b1;
          end else begin
            write      = 1'b1;
            byteenable = store_byteenable(opcode, byte_addressing);
          end
          if (waitrequest) begin
            bus_stall = 1'b1;
          end else if (is_load(opcode)) begin
            state_d = S_LOAD;
          end else begin
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
        end
        S_LOAD: begin
          reg_commit      = 1'b1;
          pc_write_enable = 1'b1;
          state_d         = S_FETCH;
        end
        S_MDWAIT: begin
          md_en = 1'b1;
          if (md_zero) begin
            hilo_commit     = 1'b1;
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
      // The last tolerated stall cycle hands over to HALT instead of retrying.
      if (bus_stall && (BUS_TIMEOUT > 0) && (to_count == TO_LAST)) begin
        state_d     = S_HALT;
        bus_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state     = state_q;
  assign active    = reset || (state_q != S_HALT);
  assign bus_error = bus_error_q;

endmodule
